// File: rtl/adc_init_seq.sv
`default_nettype none
// ============================================================================
//  Module   : adc_init_seq
//  Purpose  : ADC power-up configuration sequencer. Waits a settle delay
//             after ADC_INIT_RST releases, then streams a table of ROM words
//             serially (CS_B/SCLK/SDATA) into one of four ADCs each, and
//             raises ADC_RDY once the whole table has been written.
//  Revision : 1.0  initial release
// ============================================================================
module adc_init_seq #(
   parameter int          NUM_WORDS = 6,        // words at ROM addresses 0..NUM_WORDS-1 (0..16)
   parameter int          DIV       = 2,        // SCLK half-period in CLK cycles (>=1)
   parameter logic [15:0] PWR_DLY   = 16'd1000, // settle cycles before first fetch (>=1)
   parameter int          GAP       = 4         // all-deselected cycles between words (>=1)
) (
   input  logic        CLK,
   input  logic        EOS,
   input  logic        ADC_INIT_RST,
   output logic [3:0]  ROM_ADDR,
   input  logic [17:0] ROM_DATA,
   output logic [3:0]  CS_B,
   output logic        SCLK,
   output logic        SDATA,
   output logic        ADC_RDY,
   output logic [2:0]  ADC_INIT_STATE
);

   // Divider counter spans one full bit period of 2*DIV cycles
   localparam int             DW        = $clog2(2 * DIV);
   localparam logic [DW-1:0]  DIV_LAST  = DW'(2 * DIV - 1);
   localparam logic [DW-1:0]  DIV_HALF  = DW'(DIV);
   localparam logic [15:0]    PWR_LAST  = PWR_DLY - 16'd1;
   localparam logic [15:0]    GAP_LAST  = 16'(GAP - 1);
   localparam logic [3:0]     LAST_ADDR = 4'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PWR_DLY = 3'd1,
      S_FETCH   = 3'd2,
      S_LOAD    = 3'd3,
      S_SHIFT   = 3'd4,
      S_GAP     = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t         state, state_nx;
   logic [15:0]    cnt, cnt_nx;         // shared settle-delay / gap counter
   logic [DW-1:0]  div_cnt, div_nx;     // position inside the current bit
   logic [3:0]     bit_cnt, bit_nx;     // bit index inside the current word
   logic [15:0]    shreg, sh_nx;        // payload, current bit at [15]
   logic [3:0]     addr, addr_nx;
   logic [3:0]     cs_b, cs_nx;
   logic           sclk, sclk_nx;
   logic           sdata, sdata_nx;
   logic           rdy, rdy_nx;

   // State and output registers; every output comes straight from a flop
   always_ff @(posedge CLK or negedge EOS) begin
      if (!EOS) begin
         state   <= S_IDLE;
         cnt     <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         addr    <= '0;
         cs_b    <= 4'hF;
         sclk    <= 1'b0;
         sdata   <= 1'b0;
         rdy     <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         div_cnt <= div_nx;
         bit_cnt <= bit_nx;
         shreg   <= sh_nx;
         addr    <= addr_nx;
         cs_b    <= cs_nx;
         sclk    <= sclk_nx;
         sdata   <= sdata_nx;
         rdy     <= rdy_nx;
      end
   end

   // Next state plus next-cycle output values (outputs default to idle levels)
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      div_nx   = div_cnt;
      bit_nx   = bit_cnt;
      sh_nx    = shreg;
      addr_nx  = addr;
      cs_nx    = 4'hF;
      sclk_nx  = 1'b0;
      sdata_nx = 1'b0;
      rdy_nx   = 1'b0;

      case (state)
         S_IDLE: begin
            cnt_nx  = '0;
            addr_nx = '0;
            if (!ADC_INIT_RST) state_nx = S_PWR_DLY;
         end
         S_PWR_DLY: begin
            if (cnt == PWR_LAST) begin
               cnt_nx  = '0;
               addr_nx = '0;
               if (NUM_WORDS == 0) begin
                  state_nx = S_DONE;
                  rdy_nx   = 1'b1;
               end else begin
                  state_nx = S_FETCH;
               end
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_FETCH: begin
            // ROM sees the address this cycle; its data is valid during Load
            state_nx = S_LOAD;
         end
         S_LOAD: begin
            sh_nx    = ROM_DATA[15:0];
            cs_nx    = ~(4'b0001 << ROM_DATA[17:16]);
            sdata_nx = ROM_DATA[15];
            div_nx   = '0;
            bit_nx   = '0;
            state_nx = S_SHIFT;
         end
         S_SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               if (bit_cnt == 4'd15) begin
                  // Word complete: deselect, clock and data back to idle
                  state_nx = S_GAP;
                  cnt_nx   = '0;
               end else begin
                  // Next bit starts with SCLK low, so data may change here
                  div_nx   = '0;
                  bit_nx   = bit_cnt + 4'd1;
                  sh_nx    = {shreg[14:0], 1'b0};
                  sdata_nx = shreg[14];
                  cs_nx    = cs_b;
               end
            end else begin
               div_nx   = div_cnt + 1'b1;
               sclk_nx  = (div_nx >= DIV_HALF);
               sdata_nx = sdata;
               cs_nx    = cs_b;
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nx = '0;
               if (addr == LAST_ADDR) begin
                  state_nx = S_DONE;
                  rdy_nx   = 1'b1;
               end else begin
                  addr_nx  = addr + 4'd1;
                  state_nx = S_FETCH;
               end
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_DONE: begin
            rdy_nx = 1'b1;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      // Restart request wins over every other transition
      if (ADC_INIT_RST) begin
         state_nx = S_IDLE;
         cnt_nx   = '0;
         div_nx   = '0;
         bit_nx   = '0;
         addr_nx  = '0;
         cs_nx    = 4'hF;
         sclk_nx  = 1'b0;
         sdata_nx = 1'b0;
         rdy_nx   = 1'b0;
      end
   end

   assign ROM_ADDR       = addr;
   assign CS_B           = cs_b;
   assign SCLK           = sclk;
   assign SDATA          = sdata;
   assign ADC_RDY        = rdy;
   assign ADC_INIT_STATE = state;

endmodule
`default_nettype wire

// File: tb/tb_adc_init_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_init_seq
//  Purpose  : Self-checking bench for adc_init_seq. Three instances share
//             clock and resets: 3 words (indices 0,1,3), 1 word (18'h2A5C3)
//             and 0 words. Each cycle every instance is compared with a
//             timeline model derived from the sequencing rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_init_seq;

   localparam int P = 10;                // settle delay
   localparam int D = 2;                 // SCLK half period
   localparam int G = 4;                 // gap length
   localparam int L = 2 + 32 * D + G;    // cycles per word: fetch, load, shift, gap

   logic        clk;
   logic        eos;
   logic        init_rst;
   logic [3:0]  addr  [3];
   logic [17:0] rdata [3];
   logic [3:0]  csb   [3];
   logic        sclk  [3];
   logic        sdata [3];
   logic        rdy   [3];
   logic [2:0]  st    [3];
   logic [17:0] rom   [3][16];

   int checks;
   int errors;
   int t;                                 // cycles since sequence start, -1 = idle

   // DUT1 serial capture and DUT2 activity monitors
   logic        prev1;
   logic [15:0] cap1;
   int          rises1;
   int          low1;
   logic [3:0]  cs1seen;
   int          act2;

   function automatic int nw(int d);
      return (d == 0) ? 3 : ((d == 1) ? 1 : 0);
   endfunction

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         adc_init_seq #(
            .NUM_WORDS (nw(g)),
            .DIV       (D),
            .PWR_DLY   (16'(P)),
            .GAP       (G)
         ) u_dut (
            .CLK            (clk),
            .EOS            (eos),
            .ADC_INIT_RST   (init_rst),
            .ROM_ADDR       (addr[g]),
            .ROM_DATA       (rdata[g]),
            .CS_B           (csb[g]),
            .SCLK           (sclk[g]),
            .SDATA          (sdata[g]),
            .ADC_RDY        (rdy[g]),
            .ADC_INIT_STATE (st[g])
         );

         // Synchronous ROM: data valid the cycle after the address changes
         always @(posedge clk) rdata[g] <= rom[g][addr[g]];
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {state, rdy, addr, cs_b, sclk, sdata} at sequence time tt
   function automatic logic [13:0] model(int d, int tt);
      int          u, w, r, k;
      logic [17:0] wd;
      logic [2:0]  s;
      logic        rd, sc, sd;
      logic [3:0]  a, cs;
      s = 3'd0; rd = 1'b0; a = 4'd0; cs = 4'hF; sc = 1'b0; sd = 1'b0;
      if (tt >= 0 && tt < P) begin
         s = 3'd1;
      end else if (tt >= P) begin
         u = tt - P;
         w = u / L;
         if (w >= nw(d)) begin
            s  = 3'd6;
            rd = 1'b1;
            a  = (nw(d) == 0) ? 4'd0 : 4'(nw(d) - 1);
         end else begin
            a  = 4'(w);
            r  = u % L;
            wd = rom[d][w];
            if (r == 0)                s = 3'd2;
            else if (r == 1)           s = 3'd3;
            else if (r < 2 + 32 * D) begin
               k  = r - 2;
               s  = 3'd4;
               cs = ~(4'b0001 << wd[17:16]);
               sc = ((k % (2 * D)) >= D);
               sd = wd[15 - k / (2 * D)];
            end else                   s = 3'd5;
         end
      end
      return {s, rd, a, cs, sc, sd};
   endfunction

   function automatic logic [13:0] actual(int d);
      return {st[d], rdy[d], addr[d], csb[d], sclk[d], sdata[d]};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
      end
   endtask

   // One clock: advance the model timeline, then compare every instance
   task automatic tick();
      @(posedge clk);
      if (!eos || init_rst) t = -1;
      else                  t = (t < 0) ? 0 : t + 1;
      @(negedge clk);
      for (int d = 0; d < 3; d++)
         check($sformatf("trace_dut%0d", d), 32'(actual(d)), 32'(model(d, t)));
      if (csb[1] != 4'hF) begin
         low1++;
         cs1seen = csb[1];
         if (sclk[1] && !prev1) begin
            rises1++;
            cap1 = {cap1[14:0], sdata[1]};
         end
      end
      prev1 = sclk[1];
      if (csb[2] != 4'hF || sclk[2]) act2++;
   endtask

   typedef struct {
      logic       eos;
      logic       rst;
      int         n;
      logic [2:0] st;
      logic       rdy;
   } vec_t;

   vec_t vt [8];

   initial begin
      checks = 0; errors = 0; t = -1;
      prev1 = 1'b0; cap1 = '0; rises1 = 0; low1 = 0; cs1seen = 4'hF; act2 = 0;
      eos = 1'b0; init_rst = 1'b1;

      for (int d = 0; d < 3; d++)
         for (int a = 0; a < 16; a++) rom[d][a] = 18'($urandom);
      rom[0][0] = {2'd0, 16'($urandom)};
      rom[0][1] = {2'd1, 16'($urandom)};
      rom[0][2] = {2'd3, 16'($urandom)};
      rom[1][0] = 18'h2A5C3;

      // {EOS, ADC_INIT_RST, cycles, expected state, expected ADC_RDY} of DUT0
      vt[0] = '{1'b0, 1'b1,   5, 3'd0, 1'b0};  // in reset
      vt[1] = '{1'b1, 1'b1,  20, 3'd0, 1'b0};  // held by ADC_INIT_RST
      vt[2] = '{1'b1, 1'b0,   5, 3'd1, 1'b0};  // settling
      vt[3] = '{1'b1, 1'b0, 215, 3'd5, 1'b0};  // last cycle of final gap
      vt[4] = '{1'b1, 1'b0,   1, 3'd6, 1'b0 | 1'b1};
      vt[5] = '{1'b1, 1'b0,  50, 3'd6, 1'b1};  // ready holds
      vt[6] = '{1'b1, 1'b1,   1, 3'd0, 1'b0};  // restart
      vt[7] = '{1'b1, 1'b0,   1, 3'd1, 1'b0};  // settling again

      for (int i = 0; i < 8; i++) begin
         eos      = vt[i].eos;
         init_rst = vt[i].rst;
         repeat (vt[i].n) tick();
         check($sformatf("tbl%0d_state", i), 32'(st[0]), 32'(vt[i].st));
         check($sformatf("tbl%0d_rdy", i),   32'(rdy[0]), 32'(vt[i].rdy));
      end

      // Restart in the middle of bit 7 of word 1 (SCLK high)
      repeat (112) tick();
      check("midword_state", 32'(st[0]),   32'd4);
      check("midword_cs",    32'(csb[0]),  32'h0000000D);
      check("midword_sclk",  32'(sclk[0]), 32'd1);
      init_rst = 1'b1;
      tick();
      check("restart_cs",   32'(csb[0]),  32'h0000000F);
      check("restart_sclk", 32'(sclk[0]), 32'd0);
      check("restart_addr", 32'(addr[0]), 32'd0);
      check("restart_rdy",  32'(rdy[0]),  32'd0);
      init_rst = 1'b0;
      repeat (221) tick();
      check("repeat_done", 32'(rdy[0]), 32'd1);

      // Asynchronous reset in the gap after word 0
      init_rst = 1'b1;
      tick();
      init_rst = 1'b0;
      repeat (78) tick();
      check("gap_state", 32'(st[0]), 32'd5);
      #2 eos = 1'b0;
      t = -1;
      #1;
      for (int d = 0; d < 3; d++)
         check($sformatf("async_rst_dut%0d", d), 32'(actual(d)), 32'(model(d, -1)));
      repeat (3) tick();
      eos = 1'b1;
      repeat (230) tick();
      check("eos_restart_done", 32'(rdy[0]), 32'd1);

      // Random release / restart points
      for (int i = 0; i < 6; i++) begin
         init_rst = 1'b0;
         repeat ($urandom_range(1, 240)) tick();
         init_rst = 1'b1;
         repeat ($urandom_range(1, 3)) tick();
      end

      // Clean full run: capture the single word of DUT1
      tick();
      cap1 = '0; rises1 = 0; low1 = 0; cs1seen = 4'hF;
      init_rst = 1'b0;
      repeat (230) tick();
      check("word_payload", 32'(cap1),    32'h0000A5C3);
      check("word_rises",   32'(rises1),  32'd16);
      check("word_cs_low",  32'(low1),    32'd64);
      check("word_cs_sel",  32'(cs1seen), 32'h0000000B);
      check("zero_words_idle_bus", 32'(act2), 32'd0);
      for (int d = 0; d < 3; d++)
         check($sformatf("final_rdy_dut%0d", d), 32'(rdy[d]), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
